// File: rtl/priority_split_arbiter.sv
// Two-master fixed-priority bus arbiter with single-outstanding split support.
// A split master is parked until its slave signals resume or a timeout forces release.
module priority_split_arbiter #(
  parameter int SPLIT_TIMEOUT = 1024,
  parameter int CNT_WIDTH     = 11
) (
  input  logic clk,
  input  logic rstn,
  input  logic breq1,
  input  logic breq2,
  input  logic ssplit,
  input  logic split_done,
  output logic bgrant1,
  output logic bgrant2,
  output logic msplit1,
  output logic msplit2,
  output logic msel,
  output logic bus_busy,
  output logic split_timeout_err
);

  typedef enum logic [1:0] {IDLE, GNT1, GNT2} state_e;
  typedef enum logic [1:0] {NONE, M1, M2} owner_e;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(SPLIT_TIMEOUT - 1);

  state_e               state_q, state_d;
  owner_e               owner_q, owner_d;
  logic                 pending_q, pending_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 timeout_fire;

  logic bgrant1_q, bgrant1_d;
  logic bgrant2_q, bgrant2_d;
  logic msplit1_q, msplit1_d;
  logic msplit2_q, msplit2_d;
  logic msel_q, msel_d;
  logic busy_q, busy_d;
  logic err_q, err_d;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      owner_q   <= NONE;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      bgrant1_q <= 1'b0;
      bgrant2_q <= 1'b0;
      msplit1_q <= 1'b0;
      msplit2_q <= 1'b0;
      msel_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      bgrant1_q <= bgrant1_d;
      bgrant2_q <= bgrant2_d;
      msplit1_q <= msplit1_d;
      msplit2_q <= msplit2_d;
      msel_q    <= msel_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    pending_d    = pending_q;
    timeout_fire = 1'b0;

    if (owner_q != NONE && split_done) pending_d = 1'b1;

    // A resume arriving on the limit cycle beats the forced release.
    if (owner_q != NONE && !pending_q && cnt_q == CNT_LAST && !split_done) begin
      timeout_fire = 1'b1;
      owner_d      = NONE;
    end

    unique case (state_q)
      IDLE: begin
        if (owner_q != NONE && pending_q) begin
          state_d   = (owner_q == M1) ? GNT1 : GNT2;
          owner_d   = NONE;
          pending_d = 1'b0;
        end else if (breq1 && owner_q != M1) begin
          state_d = GNT1;
        end else if (breq2 && owner_q != M2) begin
          state_d = GNT2;
        end
      end
      GNT1: begin
        if (ssplit && owner_q == NONE) begin
          state_d = IDLE;
          owner_d = M1;
        end else if (!breq1) begin
          state_d = IDLE;
        end
      end
      GNT2: begin
        if (ssplit && owner_q == NONE) begin
          state_d = IDLE;
          owner_d = M2;
        end else if (!breq2) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (owner_q != NONE && !pending_q && owner_d != NONE)
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    else
      cnt_d = '0;
  end

  always_comb begin
    bgrant1_d = (state_d == GNT1);
    bgrant2_d = (state_d == GNT2);
    msplit1_d = (owner_d == M1);
    msplit2_d = (owner_d == M2);
    busy_d    = (state_d != IDLE);
    err_d     = timeout_fire;
    msel_d    = msel_q;
    if (state_d == GNT2)      msel_d = 1'b1;
    else if (state_d == GNT1) msel_d = 1'b0;
  end

  assign bgrant1           = bgrant1_q;
  assign bgrant2           = bgrant2_q;
  assign msplit1           = msplit1_q;
  assign msplit2           = msplit2_q;
  assign msel              = msel_q;
  assign bus_busy          = busy_q;
  assign split_timeout_err = err_q;

endmodule

// File: tb/tb_priority_split_arbiter.sv
// Directed bench for priority_split_arbiter: a cycle table plus hand-written
// sequences for long grants, split timeout and resume-at-limit.
module tb_priority_split_arbiter;

  logic clk;
  logic rstn, breq1, breq2, ssplit, split_done;
  logic bgrant1, bgrant2, msplit1, msplit2, msel, bus_busy, split_timeout_err;

  int vectors = 0;
  int fails   = 0;

  // Expected output packing: {bgrant1, bgrant2, msplit1, msplit2, msel, bus_busy, err}
  localparam logic [6:0] G1      = 7'b1000010;
  localparam logic [6:0] G2      = 7'b0100110;
  localparam logic [6:0] IDLE0   = 7'b0000000;
  localparam logic [6:0] IDLE1   = 7'b0000100;
  localparam logic [6:0] SPL2    = 7'b0001100;

  typedef struct {
    logic       rstn;
    logic       b1;
    logic       b2;
    logic       ss;
    logic       sd;
    logic [6:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  priority_split_arbiter #(.SPLIT_TIMEOUT(16), .CNT_WIDTH(5)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .breq1            (breq1),
    .breq2            (breq2),
    .ssplit           (ssplit),
    .split_done       (split_done),
    .bgrant1          (bgrant1),
    .bgrant2          (bgrant2),
    .msplit1          (msplit1),
    .msplit2          (msplit2),
    .msel             (msel),
    .bus_busy         (bus_busy),
    .split_timeout_err(split_timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(logic r, logic b1, logic b2, logic ss, logic sd,
                                 logic [6:0] exp, string name);
    vec_t v;
    v.rstn = r; v.b1 = b1; v.b2 = b2; v.ss = ss; v.sd = sd;
    v.exp = exp; v.name = name;
    return v;
  endfunction

  task automatic applyStimulus(input logic r, input logic b1, input logic b2,
                               input logic ss, input logic sd);
    @(negedge clk);
    rstn = r; breq1 = b1; breq2 = b2; ssplit = ss; split_done = sd;
  endtask

  task automatic checkOutput(input logic [6:0] exp, input string name);
    logic [6:0] act;
    @(posedge clk);
    #1;
    act = {bgrant1, bgrant2, msplit1, msplit2, msel, bus_busy, split_timeout_err};
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %b expected %b (g1 g2 ms1 ms2 msel busy err)",
               name, act, exp);
    end
  endtask

  initial begin
    rstn = 1'b0; breq1 = 1'b0; breq2 = 1'b0; ssplit = 1'b0; split_done = 1'b0;

    vecs.push_back(mkVec(0,0,0,0,0, IDLE0,      "reset"));
    vecs.push_back(mkVec(0,1,1,0,0, IDLE0,      "reset_with_req"));
    vecs.push_back(mkVec(1,1,1,0,0, G1,         "both_req_m1_wins"));
    vecs.push_back(mkVec(1,1,1,0,0, G1,         "hold_m1"));
    vecs.push_back(mkVec(1,1,1,1,0, 7'b0010000, "split_m1"));
    vecs.push_back(mkVec(1,1,1,0,0, 7'b0110110, "m2_while_m1_split"));
    vecs.push_back(mkVec(1,1,1,1,0, 7'b0110110, "second_ssplit_ignored"));
    vecs.push_back(mkVec(1,1,0,0,1, 7'b0010100, "done_and_drop_m2"));
    vecs.push_back(mkVec(1,0,1,0,0, G1,         "resume_m1"));
    vecs.push_back(mkVec(1,0,1,0,0, IDLE0,      "release_m1"));
    vecs.push_back(mkVec(1,0,1,0,0, G2,         "grant_m2"));
    vecs.push_back(mkVec(1,0,1,0,1, G2,         "done_no_owner"));
    vecs.push_back(mkVec(1,0,0,0,0, IDLE1,      "idle_msel_hold"));
    vecs.push_back(mkVec(1,0,0,1,0, IDLE1,      "ssplit_in_idle"));
    vecs.push_back(mkVec(1,0,0,0,1, IDLE1,      "stray_done_idle"));
    vecs.push_back(mkVec(1,1,0,0,0, G1,         "m1_after_stray_done"));
    vecs.push_back(mkVec(1,0,0,1,0, 7'b0010000, "ssplit_beats_drop"));
    vecs.push_back(mkVec(1,0,0,0,1, 7'b0010000, "pending_set"));
    vecs.push_back(mkVec(0,0,0,0,0, IDLE0,      "reset_mid_split"));
    vecs.push_back(mkVec(1,0,0,0,0, IDLE0,      "no_resume_after_reset"));
    vecs.push_back(mkVec(1,0,1,0,0, G2,         "m2_after_reset"));
    vecs.push_back(mkVec(1,0,0,0,0, IDLE1,      "m2_release"));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rstn, vecs[i].b1, vecs[i].b2, vecs[i].ss, vecs[i].sd);
      checkOutput(vecs[i].exp, vecs[i].name);
    end

    // Master 2 holds the bus for 8 cycles despite master 1 requesting
    applyStimulus(1,0,1,0,0); checkOutput(G2, "m2_grant_long");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1,1,1,0,0); checkOutput(G2, "m2_hold_no_preempt");
    end
    applyStimulus(1,1,0,0,0); checkOutput(IDLE1, "idle_gap");
    applyStimulus(1,1,0,0,0); checkOutput(G1,    "m1_after_gap");

    // Split master 2 times out while it keeps requesting
    applyStimulus(1,0,0,0,0); checkOutput(IDLE0, "m1_release");
    applyStimulus(1,0,1,0,0); checkOutput(G2,    "m2_grant_pre_split");
    applyStimulus(1,0,1,1,0); checkOutput(SPL2,  "split_m2");
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1,0,1,0,0); checkOutput(SPL2, "split_m2_wait");
    end
    applyStimulus(1,0,1,0,0); checkOutput(7'b0000101, "timeout_err");
    applyStimulus(1,0,1,0,0); checkOutput(G2,         "regrant_m2");

    // Resume arriving on the limit cycle suppresses the timeout
    applyStimulus(1,0,1,1,0); checkOutput(SPL2, "split_m2_again");
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1,0,0,0,0); checkOutput(SPL2, "split_m2_wait2");
    end
    applyStimulus(1,0,0,0,1); checkOutput(SPL2,  "done_at_limit");
    applyStimulus(1,0,0,0,0); checkOutput(G2,    "resume_m2");
    applyStimulus(1,0,0,0,0); checkOutput(IDLE1, "resume_m2_release");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
